// File: rtl/vga_tile_painter.sv
// vga_tile_painter
//   Pixel-colour stage that sits after the VGA timing generator. It tracks the
//   current pixel column/row from the raw sync and display-enable strobes,
//   looks up a 3-bit colour per 16x16 tile in an internal tile RAM, and drives
//   registered R/G/B outputs. The syncs are delayed so they stay aligned with
//   the colour. After every reset the tile RAM is cleared to black, one entry
//   per clock. Once the clear has finished, the host may write tiles while
//   the display is blanking.
//
//   Optional build macro: VGA_TILE_GRID_EN. When it is defined, the first
//   column and first row of every tile are drawn as white grid lines.
//
// Ports:
//   Clock       system clock, rising edge
//   Reset       asynchronous, active-low reset
//   iHsync      Hsync from the timing stage (active low)
//   iVsync      Vsync from the timing stage (active low)
//   iDisplayEn  high during the visible part of a line
//   iWrValid    host write request
//   iWrAddr     tile index (row*40 + col)
//   iWrColor    tile colour {R,G,B}
//   oWrReady    write accepted when iWrValid && oWrReady
//   oClearDone  high once the post-reset RAM clear has completed
//   oHsync      iHsync delayed 2 clocks
//   oVsync      iVsync delayed 2 clocks
//   oRed/oGreen/oBlue  registered pixel colour, 2 clocks of latency
module vga_tile_painter #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned PIX_DIV    = 4,
    parameter int unsigned TILE_SHIFT = 4,
    parameter int unsigned ADDR_W     = 11
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iHsync,
    input  logic              iVsync,
    input  logic              iDisplayEn,
    input  logic              iWrValid,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [2:0]        iWrColor,
    output logic              oWrReady,
    output logic              oClearDone,
    output logic              oHsync,
    output logic              oVsync,
    output logic              oRed,
    output logic              oGreen,
    output logic              oBlue
);

    localparam int unsigned TILES_X    = H_ACTIVE >> TILE_SHIFT;
    localparam int unsigned TILES_Y    = V_ACTIVE >> TILE_SHIFT;
    localparam int unsigned TILE_COUNT = TILES_X * TILES_Y;
    localparam int unsigned COL_W      = $clog2(H_ACTIVE);
    localparam int unsigned ROW_W      = $clog2(V_ACTIVE);
    localparam int unsigned DIV_W      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] clear_addr;
    logic              clear_last;

    // Single RAM write port, shared between the clear sweep and the host.
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [2:0]        ram_wdata;
    logic              ram_show;

    logic [2:0] tile_ram [TILE_COUNT];

    logic [DIV_W-1:0] div;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             de_q;

    logic [ADDR_W-1:0] tile_addr;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_de;
    logic              s1_hs;
    logic              s1_vs;
    logic [2:0]        pix_next;

`ifdef VGA_TILE_GRID_EN
    logic on_grid;
    logic s1_grid;
`endif

    assign clear_last = (clear_addr == ADDR_W'(TILE_COUNT - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        next_state = state;
        if (state == CLEAR && clear_last) begin
            next_state = RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        oWrReady  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = clear_addr;
        ram_wdata = '0;
        ram_show  = 1'b0;
        case (state)
            CLEAR: begin
                ram_we = 1'b1;
            end
            RUN: begin
                oWrReady = !iDisplayEn;
                ram_show = 1'b1;
                // Out-of-range writes are handshaken but never reach the RAM.
                if (iWrValid && !iDisplayEn && (iWrAddr < ADDR_W'(TILE_COUNT))) begin
                    ram_we    = 1'b1;
                    ram_waddr = iWrAddr;
                    ram_wdata = iWrColor;
                end
            end
            default: ;
        endcase
    end

    // Clear sweep address and completion flag.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clear_addr <= '0;
            oClearDone <= 1'b0;
        end else if (state == CLEAR) begin
            if (clear_last) begin
                oClearDone <= 1'b1;
            end else begin
                clear_addr <= clear_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (ram_we) begin
            tile_ram[ram_waddr] <= ram_wdata;
        end
    end

    // ---------------- Pixel position tracking ----------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            div  <= '0;
            col  <= '0;
            row  <= '0;
            de_q <= 1'b0;
        end else begin
            de_q <= iDisplayEn;

            if (!iDisplayEn) begin
                div <= '0;
                col <= '0;
            end else if (div == DIV_W'(PIX_DIV - 1)) begin
                div <= '0;
                if (col != COL_W'(H_ACTIVE - 1)) begin
                    col <= col + COL_W'(1);
                end
            end else begin
                div <= div + DIV_W'(1);
            end

            // The Vsync clear takes priority over a simultaneous line end.
            if (!iVsync) begin
                row <= '0;
            end else if (de_q && !iDisplayEn && (row != ROW_W'(V_ACTIVE - 1))) begin
                row <= row + ROW_W'(1);
            end
        end
    end

    always_comb begin
        tile_addr = ADDR_W'(row >> TILE_SHIFT) * ADDR_W'(TILES_X)
                  + ADDR_W'(col >> TILE_SHIFT);
    end

`ifdef VGA_TILE_GRID_EN
    always_comb begin
        on_grid = (col[TILE_SHIFT-1:0] == '0) || (row[TILE_SHIFT-1:0] == '0);
    end
`endif

    // ---------------- Read pipeline (2 clocks) ----------------
    // The RAM read is folded into the output register. Its address comes from
    // S1, so a same-cycle write to that entry is not yet visible (old data).
    always_comb begin
        pix_next = '0;
        if (s1_de && ram_show) begin
            pix_next = tile_ram[s1_addr];
        end
`ifdef VGA_TILE_GRID_EN
        if (s1_de && s1_grid) begin
            pix_next = '1;
        end
`endif
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            s1_addr <= '0;
            s1_de   <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            oHsync  <= 1'b1;
            oVsync  <= 1'b1;
            {oRed, oGreen, oBlue} <= '0;
        end else begin
            s1_addr <= tile_addr;
            s1_de   <= iDisplayEn;
            s1_hs   <= iHsync;
            s1_vs   <= iVsync;
            oHsync  <= s1_hs;
            oVsync  <= s1_vs;
            {oRed, oGreen, oBlue} <= pix_next;
        end
    end

`ifdef VGA_TILE_GRID_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            s1_grid <= 1'b0;
        end else begin
            s1_grid <= on_grid;
        end
    end
`endif

endmodule

// File: tb/tb_vga_tile_painter.sv
// tb_vga_tile_painter
//   Directed and randomised stimulus for vga_tile_painter. A behavioural
//   reference model tracks the tile contents, the pixel position (derived
//   from display-enable run lengths and line-end counts), and the 2-clock
//   output latency. Every clock, the model's expected outputs are compared
//   against the design's outputs. When VGA_TILE_GRID_EN is defined, the model
//   also applies the grid-line override.
module tb_vga_tile_painter;

    localparam int TILES = 1200;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iHsync = 1'b1;
    logic        iVsync = 1'b1;
    logic        iDisplayEn = 1'b0;
    logic        iWrValid = 1'b0;
    logic [10:0] iWrAddr = '0;
    logic [2:0]  iWrColor = '0;
    logic        oWrReady;
    logic        oClearDone;
    logic        oHsync;
    logic        oVsync;
    logic        oRed;
    logic        oGreen;
    logic        oBlue;

    always #5 Clock = ~Clock;

    vga_tile_painter #(
        .H_ACTIVE  (640),
        .V_ACTIVE  (480),
        .PIX_DIV   (4),
        .TILE_SHIFT(4),
        .ADDR_W    (11)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iHsync    (iHsync),
        .iVsync    (iVsync),
        .iDisplayEn(iDisplayEn),
        .iWrValid  (iWrValid),
        .iWrAddr   (iWrAddr),
        .iWrColor  (iWrColor),
        .oWrReady  (oWrReady),
        .oClearDone(oClearDone),
        .oHsync    (oHsync),
        .oVsync    (oVsync),
        .oRed      (oRed),
        .oGreen    (oGreen),
        .oBlue     (oBlue)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [2:0] ref_ram [TILES];
    int clear_edges;   // clock edges seen since reset release, while clearing
    int de_run;        // consecutive display-enable cycles before this one
    int m_row;         // completed visible lines since the last Vsync
    bit prev_de;
    bit pend_de;       // pixel captured one clock ago, read on the next edge
    bit pend_grid;
    int pend_idx;
    bit pend_hs;
    bit pend_vs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        foreach (ref_ram[i]) ref_ram[i] = 3'b000;
        clear_edges = 0;
        de_run      = 0;
        m_row       = 0;
        prev_de     = 1'b0;
        pend_de     = 1'b0;
        pend_grid   = 1'b0;
        pend_idx    = 0;
        pend_hs     = 1'b1;
        pend_vs     = 1'b1;
    endtask

    task automatic check_reset_values();
        check("rst_rgb", {oRed, oGreen, oBlue}, 3'b000);
        check("rst_hsync", oHsync, 1'b1);
        check("rst_vsync", oVsync, 1'b1);
        check("rst_clear_done", oClearDone, 1'b0);
        check("rst_wr_ready", oWrReady, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset      = 1'b0;
        iDisplayEn = 1'b0;
        iHsync     = 1'b1;
        iVsync     = 1'b1;
        iWrValid   = 1'b0;
        model_reset();
        #1 check_reset_values();
        repeat (3) @(posedge Clock);
        #1 check_reset_values();
        Reset = 1'b1;
    endtask

    // One clock: drive inputs, check ready, advance the model, check outputs.
    task automatic step(input bit de, input bit hs, input bit vs,
                        input bit wv, input int wa, input int wc);
        logic [2:0] exp_rgb;
        bit running;
        bit exp_hs;
        bit exp_vs;
        int col;
        @(negedge Clock);
        iDisplayEn = de;
        iHsync     = hs;
        iVsync     = vs;
        iWrValid   = wv;
        iWrAddr    = 11'(wa);
        iWrColor   = 3'(wc);
        running = (clear_edges >= TILES);
        #1 check("wr_ready", oWrReady, running && !de);

        // Output after this edge: the pixel captured last clock, read from
        // the RAM contents before this clock's write lands.
        exp_rgb = 3'b000;
        if (pend_de && running) exp_rgb = ref_ram[pend_idx];
`ifdef VGA_TILE_GRID_EN
        if (pend_de && pend_grid) exp_rgb = 3'b111;
`endif
        exp_hs = pend_hs;
        exp_vs = pend_vs;

        col = de_run / 4;
        if (col > 639) col = 639;
        pend_de   = de;
        pend_idx  = (m_row / 16) * 40 + (col / 16);
        pend_grid = ((col % 16) == 0) || ((m_row % 16) == 0);
        pend_hs   = hs;
        pend_vs   = vs;

        if (running && wv && !de && wa < TILES) ref_ram[wa] = 3'(wc);

        de_run = de ? de_run + 1 : 0;
        if (!vs) m_row = 0;
        else if (prev_de && !de && m_row < 479) m_row++;
        prev_de = de;
        if (!running) clear_edges++;

        @(posedge Clock);
        #1;
        check("rgb", {oRed, oGreen, oBlue}, exp_rgb);
        check("hsync", oHsync, exp_hs);
        check("vsync", oVsync, exp_vs);
        check("clear_done", oClearDone, clear_edges >= TILES);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Partial clear, with ignored write attempts, then a reset mid-clear.
        for (int i = 0; i < 500; i++)
            step(1'b0, 1'b1, 1'b1, 1'($urandom % 2), int'($urandom_range(0, 1199)), int'($urandom % 8));
        do_reset();
        for (int i = 0; i < 1205; i++)
            step(1'b0, 1'b1, 1'b1, 1'($urandom % 2), int'($urandom_range(0, 1199)), int'($urandom % 8));

        // Random tile writes in the top three tile rows, then directed ones.
        for (int i = 0; i < 30; i++)
            step(1'b0, 1'b1, 1'b1, 1'b1, int'($urandom_range(0, 119)), int'($urandom % 8));
        step(1'b0, 1'b1, 1'b1, 1'b1, 39, int'($urandom_range(1, 7)));
        step(1'b0, 1'b1, 1'b1, 1'b1, 1199, 5);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1300, 7);
        step(1'b0, 1'b1, 1'b1, 1'b1, 41, 4);
        // Write held during display is refused, then taken in blanking.
        step(1'b1, 1'b1, 1'b1, 1'b1, 0, 6);
        step(1'b0, 1'b1, 1'b1, 1'b1, 0, 6);

        // Frame scan of rows 0..40, 48 pixels each, random Hsync. The first
        // blanking cycle rewrites the tile that was just shown.
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int r = 0; r <= 40; r++) begin
            for (int p = 0; p < 48 * 4; p++)
                step(1'b1, 1'($urandom % 2), 1'b1, 1'b0, 0, 0);
            step(1'b0, 1'b0, 1'b1, 1'($urandom % 2), (r / 16) * 40 + 2, int'($urandom % 8));
            step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        end

        // 702-pixel line: column saturates and tile 39 keeps showing.
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int p = 0; p < 702 * 4; p++)
            step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1300, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);

        // Fully random strobes, mostly with Vsync inactive.
        for (int i = 0; i < 200; i++)
            step(1'($urandom % 2), 1'($urandom % 2), 1'(($urandom % 4) != 0),
                 1'($urandom % 2), int'($urandom_range(0, 1300)), int'($urandom % 8));

        // Reset during RUN, then check that the bottom-right tile reads back black.
        do_reset();
        for (int i = 0; i < 1202; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int r = 0; r < 464; r++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
            step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        end
        for (int p = 0; p < 636 * 4; p++)
            step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_tile_painter.md
Name: vga_tile_painter

Overview:
- Pixel-colour stage directly downstream of the VGA sync/timing generator.
- Consumes the raw Hsync, Vsync and display-enable strobes and tracks the current pixel column and row.
- Looks up a 3-bit colour per 16x16-pixel tile from an internal tile RAM and drives registered Red/Green/Blue outputs, with sync outputs delayed to stay aligned.
- A host-side write port loads the tile RAM during blanking; after every reset the whole RAM is cleared to black.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- PIX_DIV, 4, clocks per pixel (the timing stage holds each pixel for 4 clocks).
- TILE_SHIFT, 4, log2 of tile edge in pixels; tile grid is (H_ACTIVE>>TILE_SHIFT) x (V_ACTIVE>>TILE_SHIFT) = 40x30.
- ADDR_W, 11, tile RAM address width; must cover 1200 entries.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iHsync  in  1  Hsync from the timing stage, active low.
- iVsync  in  1  Vsync from the timing stage, active low.
- iDisplayEn  in  1  high while the timing stage is in the visible part of a line.
- iWrValid  in  1  host write request.
- iWrAddr  in  ADDR_W  tile index, computed as row*40 + col.
- iWrColor  in  3  colour bits {R,G,B}.
- oWrReady  out  1  write accepted in any cycle where iWrValid and oWrReady are both high.
- oClearDone  out  1  high once the post-reset RAM clear has completed.
- oHsync  out  1  iHsync delayed 2 clocks.
- oVsync  out  1  iVsync delayed 2 clocks.
- oRed  out  1  red pixel bit.
- oGreen  out  1  green pixel bit.
- oBlue  out  1  blue pixel bit.

Behaviour:
- Reset (asynchronous, active-low) values:
  - oRed, oGreen, oBlue = 0; oHsync = oVsync = 1; oClearDone = 0; oWrReady = 0.
  - Pixel counters and divider = 0; FSM enters CLEAR with clear address 0.
- FSM state CLEAR:
  - Writes 3'b000 to address 0..1199, one address per clock.
  - oWrReady = 0; colour outputs forced to 0.
  - After writing address 1199, moves to RUN and sets oClearDone = 1.
- FSM state RUN:
  - oWrReady = !iDisplayEn (combinational), so the host writes only during blanking.
  - An accepted write with iWrAddr >= 1200 is dropped silently but still counts as accepted.
- Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from address 0.
- Divider and column counter:
  - Divider counts 0..PIX_DIV-1 while iDisplayEn = 1; the column increments on divider wrap.
  - Column saturates at H_ACTIVE-1.
  - Divider and column clear in any cycle where iDisplayEn = 0.
- Row counter:
  - Increments on the falling edge of iDisplayEn, detected with a 1-cycle registered copy.
  - Saturates at V_ACTIVE-1.
  - Clears while iVsync = 0; if both happen in the same cycle, the clear wins.
- Tile address = (row>>TILE_SHIFT)*40 + (col>>TILE_SHIFT).
- Read pipeline, fixed latency 2 clocks:
  - S1 registers the address, display-enable, iHsync and iVsync.
  - S2 registers the RAM read data and the delayed syncs.
  - Colour outputs = RAM data when the S1 display-enable is 1, else 0.
- RAM: single write port and synchronous read; a write and a read to the same address in the same cycle returns the old data.

Optional Feature:
- Macro: VGA_TILE_GRID_EN.
- Defined:
  - Any visible pixel with col[TILE_SHIFT-1:0] == 0 or row[TILE_SHIFT-1:0] == 0 outputs 3'b111 (white grid line), overriding RAM data.
  - Latency stays 2 clocks.
  - The override is also active in CLEAR.
- Undefined: no override logic is synthesised; output is pure RAM data.

Test Plan:
- Reset low for 3 clocks, then high -> outputs at reset values; oClearDone rises exactly 1200 clocks after reset release; an address-1199 readback is 0.
- During blanking, write addr 41 = 3'b100 (tile row 1, col 1) -> oRed = 1, oGreen = 0, oBlue = 0 exactly for pixels col 16..31 on rows 16..31; black elsewhere; colour change 2 clocks after the corresponding iDisplayEn-aligned pixel clock.
- iWrValid held high during iDisplayEn = 1 -> oWrReady = 0 and RAM unchanged; write completes in the first blanking cycle.
- Drive 700 pixels (2800 clocks) of iDisplayEn -> column saturates at 639 and output keeps the tile-39 colour; write to addr 1300 -> no RAM change.
- Toggle iHsync/iVsync -> oHsync/oVsync follow with exactly 2 clocks of delay; row counter returns to 0 on iVsync = 0.
- With VGA_TILE_GRID_EN defined, all-black RAM -> pixel (16,5) and pixel (3,32) are 3'b111, pixel (17,17) is 3'b000.
